// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage -- instruction decode stage of a simple ARM-like 5-stage pipeline.
//
// Decodes the fetched word, reads two operands from a 15-entry register file
// (r0..r14; index 15 reads as the incoming PC+4), checks the NZCV condition
// and raises a combinational hazard when a source register is still being
// produced by the EXE or MEM stage. The results are captured in the ID/EXE
// output register, which loads a bubble on flush or hazard.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pc_in, instruction  PC+4 and fetched word from IF
//   flush               branch taken: squash the instruction being decoded
//   wb_en_in, wb_dest,
//   wb_value            register file write port (from WB)
//   status              NZCV flags, bit3=N .. bit0=V
//   exe_wb_en/exe_dest,
//   mem_wb_en/mem_dest  in-flight destinations used for hazard detection
//   hazard              combinational stall request to fetch
//   pc_out .. src2      registered ID/EXE outputs
// ----------------------------------------------------------------------------
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction,
    input  logic        flush,
    input  logic        wb_en_in,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic [3:0]  status,
    input  logic        exe_wb_en,
    input  logic        mem_wb_en,
    input  logic [3:0]  exe_dest,
    input  logic [3:0]  mem_dest,
    output logic        hazard,
    output logic [31:0] pc_out,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        b,
    output logic        s,
    output logic        imm,
    output logic [3:0]  exe_cmd,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm24,
    output logic [3:0]  dest,
    output logic [3:0]  src1,
    output logic [3:0]  src2
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0] cond_f;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] rn_idx;
    logic [3:0] rd_idx;
    logic [3:0] rm_idx;

    assign cond_f = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn_idx = instruction[19:16];
    assign rd_idx = instruction[15:12];
    assign rm_idx = instruction[3:0];

    // ------------------------------------------------------------------
    // Register file r0..r14. It needs an asynchronous clear, so it is built
    // from flip-flops rather than block RAM.
    // ------------------------------------------------------------------
    logic [31:0] rf_reg [0:14];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (wb_en_in && (wb_dest != 4'd15)) begin
            rf_reg[wb_dest] <= wb_value;
        end
    end

    // ------------------------------------------------------------------
    // Control decode (before condition gating)
    // ------------------------------------------------------------------
    logic [3:0] cmd_dec;
    logic       wb_dec, mr_dec, mw_dec, b_dec, s_dec, uses_rn_dec;

    always_comb begin
        cmd_dec     = 4'b0000;
        wb_dec      = 1'b0;
        mr_dec      = 1'b0;
        mw_dec      = 1'b0;
        b_dec       = 1'b0;
        s_dec       = 1'b0;
        uses_rn_dec = 1'b0;
        case (mode)
            2'b00: begin
                // Defined data-processing ops update flags per S and read Rn,
                // except MOV/MVN which only use the second operand.
                s_dec       = s_bit;
                uses_rn_dec = 1'b1;
                case (opcode)
                    4'b1101: begin cmd_dec = 4'b0001; wb_dec = 1'b1; uses_rn_dec = 1'b0; end
                    4'b1111: begin cmd_dec = 4'b1001; wb_dec = 1'b1; uses_rn_dec = 1'b0; end
                    4'b0100: begin cmd_dec = 4'b0010; wb_dec = 1'b1; end
                    4'b0101: begin cmd_dec = 4'b0011; wb_dec = 1'b1; end
                    4'b0010: begin cmd_dec = 4'b0100; wb_dec = 1'b1; end
                    4'b0110: begin cmd_dec = 4'b0101; wb_dec = 1'b1; end
                    4'b0000: begin cmd_dec = 4'b0110; wb_dec = 1'b1; end
                    4'b1100: begin cmd_dec = 4'b0111; wb_dec = 1'b1; end
                    4'b0001: begin cmd_dec = 4'b1000; wb_dec = 1'b1; end
                    4'b1010: begin cmd_dec = 4'b0100; end
                    4'b1000: begin cmd_dec = 4'b0110; end
                    default: begin
                        // Undefined opcode decodes as a nop.
                        s_dec       = 1'b0;
                        uses_rn_dec = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                cmd_dec     = 4'b0010;
                uses_rn_dec = 1'b1;
                if (s_bit) begin
                    mr_dec = 1'b1;
                    wb_dec = 1'b1;
                end else begin
                    mw_dec = 1'b1;
                end
            end
            2'b10: begin
                b_dec = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Condition check against NZCV
    // ------------------------------------------------------------------
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ok;

    assign {flag_n, flag_z, flag_c, flag_v} = status;

    always_comb begin
        cond_ok = 1'b0;
        case (cond_f)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // A failed condition turns the instruction into a nop for every side
    // effect, but exe_cmd is still forwarded unchanged.
    logic wb_next, mr_next, mw_next, b_next, s_next, uses_rn;

    assign wb_next = wb_dec      & cond_ok;
    assign mr_next = mr_dec      & cond_ok;
    assign mw_next = mw_dec      & cond_ok;
    assign b_next  = b_dec       & cond_ok;
    assign s_next  = s_dec       & cond_ok;
    assign uses_rn = uses_rn_dec & cond_ok;

    // ------------------------------------------------------------------
    // Operand selection, register reads and hazard detection
    // ------------------------------------------------------------------
    logic [3:0]  src1_next, src2_next;
    logic        two_src;
    logic [31:0] val_rn_next, val_rm_next;

    // Stores read the data register Rd through the second read port.
    assign src1_next = rn_idx;
    assign src2_next = mw_next ? rd_idx : rm_idx;
    assign two_src   = !i_bit | mw_next;

    // Index 15 reads the PC; otherwise a same-cycle writeback is forwarded.
    assign val_rn_next = (src1_next == 4'd15) ? pc_in :
                         (wb_en_in && (wb_dest == src1_next)) ? wb_value :
                         rf_reg[src1_next];
    assign val_rm_next = (src2_next == 4'd15) ? pc_in :
                         (wb_en_in && (wb_dest == src2_next)) ? wb_value :
                         rf_reg[src2_next];

    assign hazard = (uses_rn & ((exe_wb_en & (exe_dest == src1_next)) |
                                (mem_wb_en & (mem_dest == src1_next)))) |
                    (two_src & ((exe_wb_en & (exe_dest == src2_next)) |
                                (mem_wb_en & (mem_dest == src2_next))));

    // ------------------------------------------------------------------
    // ID/EXE output register: flush and hazard both insert a full bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || hazard) begin
            pc_out        <= '0;
            wb_en         <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            imm           <= 1'b0;
            exe_cmd       <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            shift_operand <= '0;
            signed_imm24  <= '0;
            dest          <= '0;
            src1          <= '0;
            src2          <= '0;
        end else begin
            pc_out        <= pc_in;
            wb_en         <= wb_next;
            mem_r_en      <= mr_next;
            mem_w_en      <= mw_next;
            b             <= b_next;
            s             <= s_next;
            imm           <= i_bit;
            exe_cmd       <= cmd_dec;
            val_rn        <= val_rn_next;
            val_rm        <= val_rm_next;
            shift_operand <= instruction[11:0];
            signed_imm24  <= instruction[23:0];
            dest          <= rd_idx;
            src1          <= src1_next;
            src2          <= src2_next;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// ----------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage. Each scenario task drives
// an instruction at the falling edge, pushes the expected ID/EXE contents to a
// scoreboard queue, and pops/compares just after the following rising edge.
// ----------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instruction;
    logic        flush;
    logic        wb_en_in;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  status;
    logic        exe_wb_en;
    logic        mem_wb_en;
    logic [3:0]  exe_dest;
    logic [3:0]  mem_dest;
    logic        hazard;
    logic [31:0] pc_out;
    logic        wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  exe_cmd;
    logic [31:0] val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic [3:0]  dest, src1, src2;

    id_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction),
        .flush(flush), .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
        .status(status), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .hazard(hazard),
        .pc_out(pc_out), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .b(b), .s(s), .imm(imm), .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm),
        .shift_operand(shift_operand), .signed_imm24(signed_imm24),
        .dest(dest), .src1(src1), .src2(src2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic        wb, mr, mw, br, sf, im;
        logic [3:0]  cmd;
        logic [31:0] rn, rm;
        logic [11:0] sh;
        logic [23:0] si;
        logic [3:0]  dst, s1, s2;
    } out_t;

    localparam logic [31:0] PC = 32'h0000_0104;

    int   errors = 0;
    int   checks = 0;
    out_t sb[$];

    function automatic out_t observed();
        return out_t'({pc_out, wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd,
                       val_rn, val_rm, shift_operand, signed_imm24, dest, src1, src2});
    endfunction

    // Expected loaded outputs: raw fields come straight from the encoding,
    // controls/operands/src2 are supplied by the caller.
    function automatic out_t exp_load(input logic [31:0] pc, input logic [31:0] ins,
                                      input logic [3:0] cmd, input logic [4:0] ctl,
                                      input logic [31:0] rn, input logic [31:0] rm,
                                      input logic [3:0] s2);
        out_t e;
        e.pc  = pc;
        {e.wb, e.mr, e.mw, e.br, e.sf} = ctl;
        e.im  = ins[25];
        e.cmd = cmd;
        e.rn  = rn;
        e.rm  = rm;
        e.sh  = ins[11:0];
        e.si  = ins[23:0];
        e.dst = ins[15:12];
        e.s1  = ins[19:16];
        e.s2  = s2;
        return e;
    endfunction

    // Register write performed under flush so the decode output is a bubble.
    task automatic wb_write(input logic [3:0] d, input logic [31:0] v);
        @(negedge clk);
        flush = 1'b1; wb_en_in = 1'b1; wb_dest = d; wb_value = v;
        @(posedge clk); #1;
        flush = 1'b0; wb_en_in = 1'b0;
    endtask

    task automatic test_reset();
        out_t got, e;
        @(posedge clk); #1;
        got = observed(); checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_state: got=%h expected=0", got); end
        @(negedge clk); rst = 1'b0;
        wb_write(4'd3, 32'h55);
        @(negedge clk);
        instruction = 32'hE0831003;   // ADD r1,r3,r3
        sb.push_back(exp_load(PC, 32'hE0831003, 4'b0010, 5'b10000, 32'h55, 32'h55, 4'd3));
        @(posedge clk); #1;
        got = observed(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL pre_reset_read: got=%h expected=%h", got, e); end
        #2; rst = 1'b1; #1;
        got = observed(); checks++;
        if (got !== '0) begin errors++; $display("FAIL async_reset: got=%h expected=0", got); end
        exe_wb_en = 1'b1; exe_dest = 4'd3; #1;
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("FAIL hazard_in_reset: got=%b expected=1", hazard); end
        wb_en_in = 1'b1; wb_dest = 4'd4; wb_value = 32'h77;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; wb_en_in = 1'b0; exe_wb_en = 1'b0; exe_dest = 4'd0;
        instruction = 32'hE0831004;   // ADD r1,r3,r4
        sb.push_back(exp_load(PC, 32'hE0831004, 4'b0010, 5'b10000, 32'h0, 32'h0, 4'd4));
        @(posedge clk); #1;
        got = observed(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL post_reset_read: got=%h expected=%h", got, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [7];
        logic [3:0]  cmd [7];
        logic [4:0]  ctl [7];
        logic [31:0] rn  [7];
        logic [31:0] rm  [7];
        logic [3:0]  s2  [7];
        out_t got, e;
        wb_write(4'd2, 32'd5);
        wb_write(4'd3, 32'd7);
        ins = '{32'hE0821003, 32'hE3A01004, 32'hE0525003, 32'hE1520003,
                32'hE0621003, 32'hE0221003, 32'hEC821003};
        cmd = '{4'b0010, 4'b0001, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        ctl = '{5'b10000, 5'b10000, 5'b10001, 5'b00001, 5'b00000, 5'b10000, 5'b00000};
        rn  = '{32'd5, 32'd0, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
        rm  = '{32'd7, 32'd0, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
        s2  = '{4'd3, 4'd4, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pc_in = 32'h200 + 32'(i) * 4;
            instruction = ins[i];
            sb.push_back(exp_load(pc_in, ins[i], cmd[i], ctl[i], rn[i], rm[i], s2[i]));
            @(posedge clk); #1;
            got = observed(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL b2b_%0d ins=%h: got=%h expected=%h", i, ins[i], got, e); end
        end
        pc_in = PC;
    endtask

    task automatic test_write_through();
        logic        wen [4];
        logic [3:0]  wd  [4];
        logic [31:0] wv  [4];
        logic [31:0] ins [4];
        logic [31:0] rn  [4];
        logic [31:0] rm  [4];
        out_t got, e;
        wen = '{1'b1, 1'b0, 1'b1, 1'b1};
        wd  = '{4'd2, 4'd2, 4'd15, 4'd3};
        wv  = '{32'h99, 32'h0, 32'hDEAD, 32'h33};
        ins = '{32'hE0821003, 32'hE0821003, 32'hE08F1003, 32'hE0821003};
        rn  = '{32'h99, 32'h99, PC, 32'h99};
        rm  = '{32'd7, 32'd7, 32'd7, 32'h33};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb_en_in = wen[i]; wb_dest = wd[i]; wb_value = wv[i];
            instruction = ins[i];
            sb.push_back(exp_load(PC, ins[i], 4'b0010, 5'b10000, rn[i], rm[i], 4'd3));
            @(posedge clk); #1;
            got = observed(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL write_through_%0d: got=%h expected=%h", i, got, e); end
        end
        wb_en_in = 1'b0;
        wb_write(4'd3, 32'd7);
    endtask

    task automatic test_condition();
        logic [3:0] cc   [8];
        logic [3:0] st   [8];
        logic       pass [8];
        logic [31:0] ins;
        out_t got, e;
        cc   = '{4'b0000, 4'b0000, 4'b1100, 4'b1011, 4'b1000, 4'b1001, 4'b1111, 4'b1101};
        st   = '{4'b0000, 4'b0100, 4'b1001, 4'b1001, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
        pass = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ins = {cc[i], 28'h0821003};   // ADD<cc> r1,r2,r3
            instruction = ins;
            status = st[i];
            sb.push_back(exp_load(PC, ins, 4'b0010, pass[i] ? 5'b10000 : 5'b00000,
                                  32'h99, 32'd7, 4'd3));
            @(posedge clk); #1;
            got = observed(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL cond_%0d cc=%b nzcv=%b: got=%h expected=%h", i, cc[i], st[i], got, e); end
        end
        status = 4'b0000;
    endtask

    task automatic test_hazard();
        logic [31:0] ins [9];
        logic        ee  [9];
        logic [3:0]  ed  [9];
        logic        me  [9];
        logic [3:0]  md  [9];
        logic        hz  [9];
        logic [3:0]  cmd [9];
        logic [4:0]  ctl [9];
        logic [31:0] rn  [9];
        logic [31:0] rm  [9];
        logic [3:0]  s2  [9];
        out_t got, e;
        ins = '{32'hE0821003, 32'hE3A01004, 32'hE0821003, 32'hE1A01003, 32'hE4024000,
                32'hEA000010, 32'hE0821003, 32'hE4024000, 32'hE4124000};
        ee  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ed  = '{4'd2, 4'd2, 4'd0, 4'd0, 4'd4, 4'd0, 4'd2, 4'd0, 4'd0};
        me  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        md  = '{4'd0, 4'd0, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4};
        hz  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        cmd = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
        ctl = '{5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b10000, 5'b00100, 5'b11000};
        rn  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h99, 32'h99, 32'h99};
        rm  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd7, 32'h0, 32'h0};
        s2  = '{4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd4, 4'd0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            instruction = ins[i];
            exe_wb_en = ee[i]; exe_dest = ed[i];
            mem_wb_en = me[i]; mem_dest = md[i];
            if (hz[i]) sb.push_back('0);
            else sb.push_back(exp_load(PC, ins[i], cmd[i], ctl[i], rn[i], rm[i], s2[i]));
            #1; checks++;
            if (hazard !== hz[i]) begin errors++; $display("FAIL hazard_flag_%0d ins=%h: got=%b expected=%b", i, ins[i], hazard, hz[i]); end
            @(posedge clk); #1;
            got = observed(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL hazard_out_%0d ins=%h: got=%h expected=%h", i, ins[i], got, e); end
        end
        exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_dest = 4'd0; mem_dest = 4'd0;
    endtask

    task automatic test_flush();
        out_t got, e;
        // Flushed LDR while r6 is written back in the same cycle.
        @(negedge clk);
        flush = 1'b1; instruction = 32'hE4124000;
        wb_en_in = 1'b1; wb_dest = 4'd6; wb_value = 32'h1234;
        sb.push_back('0);
        @(posedge clk); #1;
        got = observed(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL flush_bubble: got=%h expected=%h", got, e); end
        // r6 must have been committed despite the flush.
        @(negedge clk);
        flush = 1'b0; wb_en_in = 1'b0; instruction = 32'hE0861003;   // ADD r1,r6,r3
        sb.push_back(exp_load(PC, 32'hE0861003, 4'b0010, 5'b10000, 32'h1234, 32'd7, 4'd3));
        @(posedge clk); #1;
        got = observed(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL flush_wb_commit: got=%h expected=%h", got, e); end
        // Flush together with a hazard still produces a bubble.
        @(negedge clk);
        flush = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd2; instruction = 32'hE0821003;
        sb.push_back('0);
        #1; checks++;
        if (hazard !== 1'b1) begin errors++; $display("FAIL flush_hazard_flag: got=%b expected=1", hazard); end
        @(posedge clk); #1;
        got = observed(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL flush_and_hazard: got=%h expected=%h", got, e); end
        @(negedge clk);
        flush = 1'b0; exe_wb_en = 1'b0; exe_dest = 4'd0;
    endtask

    initial begin
        rst = 1'b1; pc_in = PC; instruction = '0; flush = 1'b0;
        wb_en_in = 1'b0; wb_dest = '0; wb_value = '0; status = '0;
        exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_dest = '0; mem_dest = '0;
        test_reset();
        test_back_to_back();
        test_write_through();
        test_condition();
        test_hazard();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
